// File: rtl/rcon_loader_if.sv
// rcon_loader_if
// Bundles the load handshake and the RCON memory port of the round-constant
// loader into one connection.
//   master : the loader side (drives handshake status and memory commands)
//   slave  : the requester / memory side (drives start and memory read data)
// Signals:
//   start                 load request into the loader
//   busy, done            load status; done is a one-cycle pulse
//   mem_in, mem_addr,
//   mem_wr_en             memory write port
//   mem_rd_en, mem_addr0  memory read port (read-back check only)
//   mem_out, mem_done     memory read data and read-valid flag
//   err, err_addr         sticky read-back mismatch flag and first bad address
interface rcon_loader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] mem_in;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_addr0;
  logic [7:0] mem_out;
  logic       mem_done;
  logic       err;
  logic [7:0] err_addr;

  modport master (
    input  start, mem_out, mem_done,
    output busy, done, mem_in, mem_addr, mem_wr_en,
           mem_rd_en, mem_addr0, err, err_addr
  );

  modport slave (
    output start, mem_out, mem_done,
    input  busy, done, mem_in, mem_addr, mem_wr_en,
           mem_rd_en, mem_addr0, err, err_addr
  );
endinterface

// File: rtl/rcon_loader.sv
// rcon_loader
// Generates the AES-128 round constants (repeated GF(2^8) doubling starting
// at RCON_INIT) and writes them to RCON memory addresses 0..NUM_ROUNDS-1
// after a start request. The sequence ends with a one-cycle done pulse.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : rcon_loader_if.master (start/busy/done handshake, memory write
//          port, memory read port, err/err_addr)
// Parameters:
//   NUM_ROUNDS : number of constants written (1..256)
//   RCON_INIT  : constant written at address 0
//   POLY       : reduction byte applied when the doubled value overflows
// Optional feature macro RCON_VERIFY_EN: when defined, every entry is read
// back after writing and compared with the regenerated constant. Mismatches
// are reported on err/err_addr. When undefined, the read port and the
// err outputs are tied to 0.
module rcon_loader #(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01,
  parameter logic [7:0] POLY       = 8'h1B
) (
  input  logic          clk,
  input  logic          rst,
  rcon_loader_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VREQ, S_VCHK, S_FIN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_ROUNDS - 1);

  state_t     state, state_nx;
  logic [7:0] rc;
  logic [7:0] idx;
  logic       last;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_WRITE;
`ifdef RCON_VERIFY_EN
      S_WRITE: if (last) state_nx = S_VREQ;
      S_VREQ:  state_nx = S_VCHK;
      S_VCHK:  state_nx = last ? S_FIN : S_VREQ;
`else
      S_WRITE: if (last) state_nx = S_FIN;
`endif
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // rc/idx restart from the first entry when leaving WRITE so the read-back
  // pass regenerates the same sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc  <= RCON_INIT;
      idx <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          rc  <= RCON_INIT;
          idx <= 8'h00;
        end
        S_WRITE: begin
          if (last) begin
            rc  <= RCON_INIT;
            idx <= 8'h00;
          end else begin
            rc  <= xtime(rc);
            idx <= idx + 8'd1;
          end
        end
        S_VCHK: begin
          rc  <= xtime(rc);
          idx <= idx + 8'd1;
        end
        default: begin
          rc  <= rc;
          idx <= idx;
        end
      endcase
    end
  end

`ifdef RCON_VERIFY_EN
  logic       err_q;
  logic [7:0] err_addr_q;

  // Only the first failing entry is recorded; the pass still runs to the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= 8'h00;
    end else if (state == S_IDLE && bus.start) begin
      err_q      <= 1'b0;
      err_addr_q <= 8'h00;
    end else if (state == S_VCHK && !err_q &&
                 (bus.mem_out != rc || !bus.mem_done)) begin
      err_q      <= 1'b1;
      err_addr_q <= idx;
    end
  end

  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^{bus.mem_out, bus.mem_done};
  assign bus.err        = 1'b0;
  assign bus.err_addr   = 8'h00;
`endif

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_in    = 8'h00;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr0 = 8'h00;
    case (state)
      S_WRITE: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = idx;
        bus.mem_in    = rc;
      end
`ifdef RCON_VERIFY_EN
      S_VREQ: begin
        bus.busy      = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr0 = idx;
      end
      S_VCHK: bus.busy = 1'b1;
`endif
      S_FIN:   bus.done = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

endmodule
